// File: rtl/sp_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sp_sram_ctrl
//  Function : Single-port synchronous SRAM with request/ready handshake,
//             byte write enables, 1- or 2-stage read pipeline, selectable
//             read-during-write behaviour and a post-reset clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
module sp_sram_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_EN = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Req,
  output logic                 Ready,
  input  logic                 WE,
  input  logic [WIDTH/8-1:0]   BE,
  input  logic [ADDR-1:0]      Address,
  input  logic [WIDTH-1:0]     Data,
  output logic [WIDTH-1:0]     Q,
  output logic                 QValid,
  output logic                 Busy
);

  localparam int              c_NBYTES = WIDTH / 8;
  localparam logic [ADDR-1:0] c_LAST   = ADDR'(DEPTH - 1);
  // One extra bit so the range compare also works when DEPTH == 2**ADDR.
  localparam logic [ADDR:0]   c_DEPTH  = (ADDR + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR-1:0]     r_clr_cnt;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [WIDTH-1:0]    r_q;
  logic                r_qv;

  logic                w_ready;
  logic                w_acc;
  logic                w_in_range;
  logic                w_clearing;
  logic [WIDTH-1:0]    w_old;
  logic [WIDTH-1:0]    w_merged;
  logic [WIDTH-1:0]    w_res;
  logic                w_res_v;
  logic                w_we;
  logic [ADDR-1:0]     w_waddr;
  logic [WIDTH-1:0]    w_wdata;
  logic [c_NBYTES-1:0] w_wbe;

  assign w_ready    = (r_state == ST_IDLE) & ~Reset;
  assign w_acc      = Req & w_ready;
  assign w_in_range = {1'b0, Address} < c_DEPTH;
  assign w_clearing = (r_state == ST_CLEAR);
  assign w_old      = w_in_range ? r_mem[Address] : '0;

  assign Ready  = w_ready;
  assign Busy   = w_clearing;
  assign Q      = r_q;
  assign QValid = r_qv;

  // Word as it will look after the byte-enabled write lands.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < c_NBYTES; i++) begin
      if (BE[i]) w_merged[8*i +: 8] = Data[8*i +: 8];
    end
  end

  // Result of the accepted access, chosen by the read-during-write mode.
  always_comb begin
    w_res_v = 1'b0;
    w_res   = w_old;
    if (w_acc) begin
      if (!WE) begin
        w_res_v = 1'b1;
      end else if (RDW_MODE == 0) begin
        w_res_v = 1'b1;
        w_res   = w_in_range ? w_merged : '0;
      end else if (RDW_MODE == 1) begin
        w_res_v = 1'b1;
      end
    end
  end

  // Single write port: the clear engine owns it during CLEAR, requests otherwise.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = Address;
    w_wdata = Data;
    w_wbe   = BE;
    if (!Reset) begin
      if (w_clearing) begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
        w_wbe   = '1;
      end else begin
        w_we    = w_acc & WE & w_in_range;
      end
    end
  end

  // Storage array; no reset, initialised only by the clear sweep.
  always_ff @(posedge Clock) begin
    if (w_we) begin
      for (int i = 0; i < c_NBYTES; i++) begin
        if (w_wbe[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM: sweep zeros through the array, then serve requests.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + ADDR'(1);
      if (r_clr_cnt == c_LAST) r_state <= ST_IDLE;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             r_p_v;
      logic [WIDTH-1:0] r_p_d;

      // Two-stage output: an intermediate register, then Q which holds until replaced.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_p_v <= 1'b0;
          r_p_d <= '0;
          r_qv  <= 1'b0;
          r_q   <= '0;
        end else begin
          r_p_v <= w_res_v;
          if (w_res_v) r_p_d <= w_res;
          r_qv  <= r_p_v;
          if (r_p_v) r_q <= r_p_d;
        end
      end
    end else begin : g_lat1
      // Single-stage output: Q captures each result and holds until the next.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_qv <= 1'b0;
          r_q  <= '0;
        end else begin
          r_qv <= w_res_v;
          if (w_res_v) r_q <= w_res;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sp_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sp_sram_ctrl
//  Function : Directed self-checking bench for sp_sram_ctrl. Three instances
//             share one stimulus stream:
//               u0 : defaults (LAT 1, WRITE_FIRST, DEPTH 16)
//               u1 : LAT 2, READ_FIRST, DEPTH 16
//               u2 : LAT 1, NO_CHANGE, DEPTH 12
//  Revision : 1.0  initial release
// ============================================================================
module tb_sp_sram_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req;
  logic        WE;
  logic [3:0]  BE;
  logic [3:0]  Address;
  logic [31:0] Data;

  logic [31:0] q0, q1, q2;
  logic        qv0, qv1, qv2;
  logic        rdy0, rdy1, rdy2;
  logic        bsy0, bsy1, bsy2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  sp_sram_ctrl #(.WIDTH(32), .DEPTH(16), .ADDR(4), .READ_LAT(1), .RDW_MODE(0), .CLEAR_EN(1)) u0 (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Ready(rdy0), .WE(WE), .BE(BE),
    .Address(Address), .Data(Data), .Q(q0), .QValid(qv0), .Busy(bsy0));

  sp_sram_ctrl #(.WIDTH(32), .DEPTH(16), .ADDR(4), .READ_LAT(2), .RDW_MODE(1), .CLEAR_EN(1)) u1 (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Ready(rdy1), .WE(WE), .BE(BE),
    .Address(Address), .Data(Data), .Q(q1), .QValid(qv1), .Busy(bsy1));

  sp_sram_ctrl #(.WIDTH(32), .DEPTH(12), .ADDR(4), .READ_LAT(1), .RDW_MODE(2), .CLEAR_EN(1)) u2 (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Ready(rdy2), .WE(WE), .BE(BE),
    .Address(Address), .Data(Data), .Q(q2), .QValid(qv2), .Busy(bsy2));

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [3:0] a, input logic [31:0] d);
    Req = 1'b1; WE = we; BE = be; Address = a; Data = d;
  endtask

  task automatic idle();
    Req = 1'b0; WE = 1'b0; BE = 4'h0; Address = 4'h0; Data = 32'h0;
  endtask

  // Wait for u0 Ready with a cycle bound; returns the number of edges taken.
  task automatic wait_ready(output int n, output logic saw_qv1);
    n = 0;
    saw_qv1 = 1'b0;
    while (!rdy0 && n < 40) begin
      tick();
      n++;
      if (qv1) saw_qv1 = 1'b1;
    end
  endtask

  // 16 back-to-back reads of addresses 0..15 with per-instance expectations.
  task automatic read_sweep(input bit zeros, input logic [31:0] u1_first);
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, 4'h0, 4'(a), 32'h0);
      tick();
      chk($sformatf("sweep_u0_qv[%0d]", a), {31'd0, qv0}, 32'd1);
      chk($sformatf("sweep_u0_q[%0d]", a), q0, zeros ? 32'd0 : 32'(a));
      chk($sformatf("sweep_u0_rdy[%0d]", a), {31'd0, rdy0}, 32'd1);
      chk($sformatf("sweep_u1_qv[%0d]", a), {31'd0, qv1}, (zeros && a == 0) ? 32'd0 : 32'd1);
      if (a > 0) chk($sformatf("sweep_u1_q[%0d]", a), q1, zeros ? 32'd0 : 32'(a - 1));
      else if (!zeros) chk("sweep_u1_q[0]", q1, u1_first);
      chk($sformatf("sweep_u2_q[%0d]", a), q2, (zeros || a >= 12) ? 32'd0 : 32'(a));
    end
    idle();
    tick();
    chk("sweep_u0_qv_end", {31'd0, qv0}, 32'd0);
    chk("sweep_u1_qv_tail", {31'd0, qv1}, 32'd1);
    chk("sweep_u1_q_tail", q1, zeros ? 32'd0 : 32'd15);
    tick();
    chk("sweep_u1_qv_end", {31'd0, qv1}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic saw;

    // ---------------- reset state ----------------
    Reset = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_q0", q0, 32'd0);
    chk("rst_qv0", {31'd0, qv0}, 32'd0);
    chk("rst_rdy0", {31'd0, rdy0}, 32'd0);
    chk("rst_busy0", {31'd0, bsy0}, 32'd1);
    chk("rst_qv1", {31'd0, qv1}, 32'd0);

    // ---------------- clear sweep, Req held high ----------------
    Reset = 1'b0;
    issue(1'b0, 4'h0, 4'h0, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("clr_rdy0[%0d]", k), {31'd0, rdy0}, (k >= 16) ? 32'd1 : 32'd0);
      chk($sformatf("clr_busy0[%0d]", k), {31'd0, bsy0}, (k >= 16) ? 32'd0 : 32'd1);
      chk($sformatf("clr_qv0[%0d]", k), {31'd0, qv0}, 32'd0);
      chk($sformatf("clr_qv1[%0d]", k), {31'd0, qv1}, 32'd0);
      chk($sformatf("clr_rdy2[%0d]", k), {31'd0, rdy2}, (k >= 12) ? 32'd1 : 32'd0);
    end
    read_sweep(1'b1, 32'd0);

    // ---------------- byte enables ----------------
    issue(1'b1, 4'hF, 4'd3, 32'hAABBCCDD);
    tick();
    chk("be_e1_u0_q", q0, 32'hAABBCCDD);
    chk("be_e1_u0_qv", {31'd0, qv0}, 32'd1);
    chk("be_e1_u1_qv", {31'd0, qv1}, 32'd0);
    chk("be_e1_u2_qv", {31'd0, qv2}, 32'd0);
    issue(1'b1, 4'b0101, 4'd3, 32'h11223344);
    tick();
    chk("be_e2_u0_q", q0, 32'hAA22CC44);
    chk("be_e2_u1_qv", {31'd0, qv1}, 32'd1);
    chk("be_e2_u1_q", q1, 32'h00000000);
    chk("be_e2_u2_qv", {31'd0, qv2}, 32'd0);
    issue(1'b0, 4'h0, 4'd3, 32'h0);
    tick();
    chk("be_e3_u0_q", q0, 32'hAA22CC44);
    chk("be_e3_u1_q", q1, 32'hAABBCCDD);
    chk("be_e3_u2_qv", {31'd0, qv2}, 32'd1);
    chk("be_e3_u2_q", q2, 32'hAA22CC44);
    idle();
    tick();
    chk("be_e4_u0_qv", {31'd0, qv0}, 32'd0);
    chk("be_e4_u0_qhold", q0, 32'hAA22CC44);
    chk("be_e4_u1_qv", {31'd0, qv1}, 32'd1);
    chk("be_e4_u1_q", q1, 32'hAA22CC44);
    tick();
    chk("be_e5_u1_qv", {31'd0, qv1}, 32'd0);

    // ---------------- read-during-write modes ----------------
    issue(1'b1, 4'hF, 4'd5, 32'h12345678);
    tick();
    chk("rdw_e1_u0_q", q0, 32'h12345678);
    issue(1'b1, 4'hF, 4'd5, 32'hCAFEF00D);
    tick();
    chk("rdw_e2_u0_q", q0, 32'hCAFEF00D);
    chk("rdw_e2_u0_qv", {31'd0, qv0}, 32'd1);
    chk("rdw_e2_u2_qv", {31'd0, qv2}, 32'd0);
    chk("rdw_e2_u2_qhold", q2, 32'hAA22CC44);
    idle();
    tick();
    chk("rdw_e3_u1_qv", {31'd0, qv1}, 32'd1);
    chk("rdw_e3_u1_q", q1, 32'h12345678);
    chk("rdw_e3_u2_qv", {31'd0, qv2}, 32'd0);
    tick();

    // ---------------- streaming ----------------
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 4'hF, 4'(i), 32'(i));
      tick();
    end
    read_sweep(1'b0, 32'd0);

    // ---------------- out of range (u2 DEPTH 12) ----------------
    issue(1'b1, 4'hF, 4'd13, 32'hFFFFFFFF);
    tick();
    chk("oor_w_u2_qv", {31'd0, qv2}, 32'd0);
    issue(1'b0, 4'h0, 4'd13, 32'h0);
    tick();
    chk("oor_r13_u2_qv", {31'd0, qv2}, 32'd1);
    chk("oor_r13_u2_q", q2, 32'h0);
    chk("oor_r13_u0_q", q0, 32'hFFFFFFFF);
    issue(1'b0, 4'h0, 4'd11, 32'h0);
    tick();
    chk("oor_r11_u2_q", q2, 32'd11);
    idle();
    tick();
    tick();

    // ---------------- reset mid-stream ----------------
    issue(1'b0, 4'h0, 4'd7, 32'h0);
    tick();
    chk("mid_acc_u0_q", q0, 32'd7);
    idle();
    Reset = 1'b1;
    tick();
    chk("mid_u1_qv", {31'd0, qv1}, 32'd0);
    chk("mid_u1_q", q1, 32'd0);
    chk("mid_u1_busy", {31'd0, bsy1}, 32'd1);
    chk("mid_u0_rdy", {31'd0, rdy0}, 32'd0);
    Reset = 1'b0;
    wait_ready(n, saw);
    chk("mid_clear_cycles", 32'(n), 32'd16);
    chk("mid_u1_no_qv", {31'd0, saw}, 32'd0);
    chk("mid_u1_rdy", {31'd0, rdy1}, 32'd1);
    chk("mid_u2_rdy", {31'd0, rdy2}, 32'd1);
    read_sweep(1'b1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
